// File: rtl/tx_pkg.sv
// Shared types and line-level constants for the serial transmit stage.
package tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int unsigned DATA_BITS = 8;
  localparam logic        START_LVL = 1'b0;
  localparam logic        STOP_LVL  = 1'b1;

endpackage

// File: rtl/bit_timer.sv
// Clearable flex counter used as the serial bit-period timer.
// Counts 1..rollover_val, rolling back to 1; clear forces 0.
module bit_timer #(
  parameter int unsigned CNT_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 clear,
  input  logic                 count_enable,
  input  logic [CNT_WIDTH-1:0] rollover_val,
  output logic [CNT_WIDTH-1:0] count_out,
  output logic                 rollover_flag
);

  logic [CNT_WIDTH-1:0] count_q, count_d;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      if (count_q == rollover_val) begin
        count_d = CNT_WIDTH'(1);
      end else begin
        count_d = count_q + CNT_WIDTH'(1);
      end
    end
  end

  // Flags the cycle whose edge brings the count to rollover_val, i.e. the last cycle of a period.
  assign rollover_flag = count_enable && (count_q == (rollover_val - CNT_WIDTH'(1)));
  assign count_out     = count_q;

endmodule

// File: rtl/tx_serializer.sv
// Async serial transmitter: pops bytes from a FWFT FIFO and sends start, 8 data bits LSB
// first, and stop, each CLKS_PER_BIT clocks long.
module tx_serializer
  import tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       fifo_empty,
  input  logic [7:0] read_data,
  output logic       read_enable,
  output logic       tx_out,
  output logic       tx_busy
);

  localparam int unsigned     CNT_WIDTH = $clog2(CLKS_PER_BIT + 1);
  localparam logic [2:0]      LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic [CNT_WIDTH-1:0] BIT_LEN = CNT_WIDTH'(CLKS_PER_BIT);

  tx_state_t            state_q, state_d;
  logic [7:0]           shift_q, shift_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic                 timer_clear;
  logic                 timer_en;
  logic                 bit_done;
  logic [CNT_WIDTH-1:0] bit_count;
  logic                 unused_count;

  bit_timer #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_bit_timer (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (timer_clear),
    .count_enable  (timer_en),
    .rollover_val  (BIT_LEN),
    .count_out     (bit_count),
    .rollover_flag (bit_done)
  );

  assign unused_count = ^bit_count;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      shift_q   <= 8'h00;
      bit_idx_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = LOAD;
      end
      LOAD: begin
        shift_d = read_data;
        state_d = START;
      end
      START: begin
        if (bit_done) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == LAST_BIT) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_done) state_d = fifo_empty ? IDLE : LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  // Timer restarts on every state change; DATA relies on its rollover between bits.
  assign timer_clear = (state_d != state_q);
  assign timer_en    = (state_q == START) || (state_q == DATA) || (state_q == STOP);

  always_comb begin
    tx_out = STOP_LVL;
    unique case (state_q)
      START:   tx_out = START_LVL;
      DATA:    tx_out = shift_q[0];
      default: tx_out = STOP_LVL;
    endcase
  end

  assign read_enable = (state_q == LOAD);
  assign tx_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_tx_serializer.sv
// Directed bench for tx_serializer: one instance at 10 clocks/bit, one at the 2-clock minimum.
module tb_tx_serializer;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       fe_a, fe_b;
  logic [7:0] rd_a, rd_b;
  logic       re_a, tx_a, busy_a;
  logic       re_b, tx_b, busy_b;

  int checks     = 0;
  int failures   = 0;
  int re_cnt_a   = 0;
  int re_cnt_b   = 0;
  int saved_cnt  = 0;

  tx_serializer #(
    .CLKS_PER_BIT (10)
  ) dut_a (
    .clk         (clk),
    .n_rst       (n_rst),
    .fifo_empty  (fe_a),
    .read_data   (rd_a),
    .read_enable (re_a),
    .tx_out      (tx_a),
    .tx_busy     (busy_a)
  );

  tx_serializer #(
    .CLKS_PER_BIT (2)
  ) dut_b (
    .clk         (clk),
    .n_rst       (n_rst),
    .fifo_empty  (fe_b),
    .read_data   (rd_b),
    .read_enable (re_b),
    .tx_out      (tx_b),
    .tx_busy     (busy_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (re_a === 1'b1) re_cnt_a++;
    if (re_b === 1'b1) re_cnt_b++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge of the LOAD cycle; checks every cycle of start, data and stop.
  // FIFO inputs change after the LOAD capture edge; optionally a byte arrives mid-STOP.
  task automatic frame_bits(input string nm, input bit use_b, input int cpb,
                            input logic [7:0] b, input logic fe_after,
                            input logic [7:0] rd_after, input bit push,
                            input logic [7:0] nxt);
    for (int j = 0; j < 10; j++) begin
      logic exp_bit;
      exp_bit = (j == 0) ? 1'b0 : ((j == 9) ? 1'b1 : b[j-1]);
      for (int c = 0; c < cpb; c++) begin
        @(negedge clk);
        chk($sformatf("%s_tx_bit%0d_c%0d", nm, j, c), use_b ? tx_b : tx_a, exp_bit);
        chk($sformatf("%s_busy_bit%0d", nm, j), use_b ? busy_b : busy_a, 1);
        chk($sformatf("%s_re_bit%0d", nm, j), use_b ? re_b : re_a, 0);
        if (j == 0 && c == 0) begin
          if (use_b) begin
            fe_b = fe_after;
            rd_b = rd_after;
          end else begin
            fe_a = fe_after;
            rd_a = rd_after;
          end
        end
        if (push && j == 9 && c == cpb / 2) begin
          fe_a = 1'b0;
          rd_a = nxt;
        end
      end
    end
  endtask

  initial begin
    n_rst = 1'b0;
    fe_a  = 1'b1;
    fe_b  = 1'b1;
    rd_a  = 8'h00;
    rd_b  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_tx_a", tx_a, 1);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_re_a", re_a, 0);
    chk("rst_tx_b", tx_b, 1);
    n_rst = 1'b1;

    // Empty FIFO: line idles high, nothing popped
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      chk("empty_tx", tx_a, 1);
      chk("empty_busy", busy_a, 0);
    end
    chk("empty_pops", re_cnt_a, 0);

    // Single byte A5
    fe_a = 1'b0;
    rd_a = 8'hA5;
    chk("a5_t_re", re_a, 0);
    @(negedge clk);
    chk("a5_load_re", re_a, 1);
    chk("a5_load_tx", tx_a, 1);
    chk("a5_load_busy", busy_a, 1);
    frame_bits("a5", 1'b0, 10, 8'hA5, 1'b1, 8'h00, 1'b0, 8'h00);
    @(negedge clk);
    chk("a5_done_busy", busy_a, 0);
    chk("a5_done_tx", tx_a, 1);
    chk("a5_done_re", re_a, 0);
    chk("a5_pops", re_cnt_a, 1);

    // Back-to-back 00 then FF
    fe_a = 1'b0;
    rd_a = 8'h00;
    @(negedge clk);
    chk("b2b_load1_re", re_a, 1);
    frame_bits("b2b0", 1'b0, 10, 8'h00, 1'b0, 8'hFF, 1'b0, 8'h00);
    @(negedge clk);
    chk("b2b_load2_re", re_a, 1);
    chk("b2b_load2_tx", tx_a, 1);
    chk("b2b_load2_busy", busy_a, 1);
    frame_bits("b2bff", 1'b0, 10, 8'hFF, 1'b1, 8'h00, 1'b0, 8'h00);
    @(negedge clk);
    chk("b2b_done_busy", busy_a, 0);
    chk("b2b_pops", re_cnt_a, 3);

    // Byte arrives during STOP: LOAD follows the last STOP cycle directly
    fe_a = 1'b0;
    rd_a = 8'h5A;
    @(negedge clk);
    chk("stop_load1_re", re_a, 1);
    frame_bits("s5a", 1'b0, 10, 8'h5A, 1'b1, 8'h00, 1'b1, 8'hC3);
    @(negedge clk);
    chk("stop_load2_re", re_a, 1);
    chk("stop_load2_busy", busy_a, 1);
    frame_bits("sc3", 1'b0, 10, 8'hC3, 1'b1, 8'h00, 1'b0, 8'h00);
    @(negedge clk);
    chk("stop_done_busy", busy_a, 0);
    chk("stop_pops", re_cnt_a, 5);

    // Minimum rate, 2 clocks per bit, byte 3C
    fe_b = 1'b0;
    rd_b = 8'h3C;
    @(negedge clk);
    chk("min_load_re", re_b, 1);
    chk("min_load_tx", tx_b, 1);
    frame_bits("m3c", 1'b1, 2, 8'h3C, 1'b1, 8'h00, 1'b0, 8'h00);
    @(negedge clk);
    chk("min_done_busy", busy_b, 0);
    chk("min_pops", re_cnt_b, 1);

    // Asynchronous reset in the middle of data bit 2 of byte 00
    fe_a = 1'b0;
    rd_a = 8'h00;
    @(negedge clk);
    chk("rst_load_re", re_a, 1);
    @(negedge clk);
    fe_a = 1'b1;
    repeat (34) @(negedge clk);
    chk("rst_mid_tx", tx_a, 0);
    chk("rst_mid_busy", busy_a, 1);
    saved_cnt = re_cnt_a;
    #2 n_rst = 1'b0;
    #1;
    chk("rst_async_tx", tx_a, 1);
    chk("rst_async_busy", busy_a, 0);
    chk("rst_async_re", re_a, 0);
    fe_a = 1'b0;
    rd_a = 8'h77;
    repeat (3) @(negedge clk);
    chk("rst_hold_re", re_a, 0);
    fe_a = 1'b1;
    n_rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("rst_after_tx", tx_a, 1);
      chk("rst_after_re", re_a, 0);
    end
    chk("rst_pops", re_cnt_a, saved_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
